branch_predictor_bimodal: RTL and testbench
===========================================

# branch_predictor_bimodal

Parametrised successor to the fetch-stage branch predictor. It holds a direct-mapped, tagged branch target buffer (BTB) with a 2-bit saturating counter per entry. Lookups return one registered prediction per fetch request. Entries are trained from the execute-stage jump report. Flush and reset use a sequential clear engine, so the table can live in plain registers or RAM without a wide asynchronous clear.

## Interface
Parameters:
- P_ENTRY_N, 16, number of BTB entries; power of two, minimum 4.
- P_INDEX_W, 4, log2(P_ENTRY_N).
- Derived: index = addr[P_INDEX_W+1:2]; tag = addr[31:P_INDEX_W+2].
- Each entry stores valid, tag, target[31:2] and counter[1:0].

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  reset, asynchronous, active-low.
- iRESET_SYNC  in  1  synchronous reset; same effect as inRESET, applied on the clock edge.
- iFLUSH  in  1  invalidates every entry (starts a clear pass).
- iSEARCH_STB  in  1  lookup request.
- iSEARCH_INST_ADDR  in  32  fetch address to look up.
- iSEARCH_LOCK  in  1  stall; search outputs hold their value.
- oSEARCH_VALID  out  1  search outputs are meaningful.
- oSEARCH_HIT  out  1  tag match on a valid entry.
- oSEARCH_PREDICT_BRANCH  out  1  predicted taken (hit and counter[1]).
- oSEARCH_ADDR  out  32  predicted target, {target, 2'b00}; zero on a miss.
- iJUMP_STB  in  1  a branch has resolved.
- iJUMP_HIT  in  1  the resolved branch was taken.
- iJUMP_ADDR  in  32  resolved branch target.
- iJUMP_INST_ADDR  in  32  address of the branch instruction.
- oBUSY  out  1  clear pass in progress.

## Operation
FSM states:
- CLEAR: a counter clr_idx writes valid=0, counter=2'b01 into entry clr_idx each cycle. After entry P_ENTRY_N-1 is written, the FSM goes to IDLE. In this state oBUSY=1, jump updates are dropped, and searches yield oSEARCH_VALID=0.
- IDLE: normal lookup and update.

Clear triggers:
- inRESET low: FSM=CLEAR, clr_idx=0, all output registers 0. oBUSY resets to 1.
- iRESET_SYNC: same as inRESET, taken synchronously; highest priority.
- iFLUSH, in any state: FSM=CLEAR, clr_idx=0, oSEARCH_VALID cleared next edge. A flush during CLEAR restarts the pass from index 0.

Update (IDLE, iJUMP_STB=1), entry selected by index of iJUMP_INST_ADDR:
- Hit (valid and tag match): counter saturating +1 if taken, saturating -1 otherwise (bounds 00 and 11). If taken, target <= iJUMP_ADDR[31:2].
- Miss, taken: allocate the entry; valid=1, tag, target, counter=2'b10. Any aliased entry is overwritten.
- Miss, not taken: no write.

Search output registers:
- When iSEARCH_LOCK=0, the output registers load on every edge:
  - oSEARCH_VALID <= iSEARCH_STB and IDLE and no flush.
  - oSEARCH_HIT <= valid and tag match.
  - oSEARCH_PREDICT_BRANCH <= hit and counter[1].
  - oSEARCH_ADDR <= hit ? {target, 2'b00} : 0.
- When iSEARCH_LOCK=1, all four outputs hold. iFLUSH and resets override the lock.

## Timing
- Search latency: 1 cycle, from strobe edge to registered outputs. Throughput: 1 search per cycle.
- Update: written at the edge where iJUMP_STB is sampled. It is visible to searches presented on the following cycle.
- Update and search to the same index in the same cycle: without the bypass, the search returns the pre-update entry (see Configuration).
- Clear pass: exactly P_ENTRY_N cycles. oBUSY falls on the edge after entry P_ENTRY_N-1 is written. A search presented in the first IDLE cycle is valid.
- After oBUSY=0, the table holds all entries invalid. The first post-clear search of any address gives HIT=0, PRED=0, ADDR=0.

## Configuration
- BRANCH_PREDICTOR_BYPASS_EN defined: when an update and a search hit the same index in the same cycle, the search sees the post-update entry (valid, tag, target and counter). This costs one comparator and a mux on the read path.
- BRANCH_PREDICTOR_BYPASS_EN undefined: the search sees the pre-update entry (read-before-write).

## Test plan
All scenarios use P_ENTRY_N=16.
- Reset release, iSEARCH_STB=1 held: oBUSY=1 for 16 cycles, oSEARCH_VALID=0 throughout. Then oBUSY=0, and the next result is VALID=1, HIT=0, ADDR=0.
- Jump taken, inst 0x100 to 0x2000; then search 0x100: VALID=1, HIT=1, PRED=1, ADDR=0x2000.
- Two not-taken updates at 0x100 (counter 10, 01, 00); search 0x100: HIT=1, PRED=0, ADDR=0x2000. Three further taken updates: PRED=1 from the second one, counter saturates at 11.
- Alias: with 0x100 trained, search 0x140 (same index, different tag): HIT=0, PRED=0, ADDR=0. Then a taken jump at 0x140 to 0x3000: search 0x100 now misses.
- iSEARCH_LOCK=1 for 3 cycles with a changing search address: outputs hold. iFLUSH asserted while locked: oSEARCH_VALID=0 next cycle, oBUSY=1 for 16 cycles.
- Same-cycle update (taken, 0x100 to 0x2000) and search 0x100 on an empty table: HIT=0 without the macro, HIT=1 and ADDR=0x2000 with BRANCH_PREDICTOR_BYPASS_EN.

Source files
------------

// File: rtl/branch_predictor_bimodal.sv
// branch_predictor_bimodal: tagged direct-mapped BTB with 2-bit counters and a sequential clear engine.
// Optional BRANCH_PREDICTOR_BYPASS_EN forwards a same-cycle update to the search read path.
module branch_predictor_bimodal #(
  parameter int P_ENTRY_N = 16,
  parameter int P_INDEX_W = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iSEARCH_STB,
  input  logic [31:0] iSEARCH_INST_ADDR,
  input  logic        iSEARCH_LOCK,
  output logic        oSEARCH_VALID,
  output logic        oSEARCH_HIT,
  output logic        oSEARCH_PREDICT_BRANCH,
  output logic [31:0] oSEARCH_ADDR,
  input  logic        iJUMP_STB,
  input  logic        iJUMP_HIT,
  input  logic [31:0] iJUMP_ADDR,
  input  logic [31:0] iJUMP_INST_ADDR,
  output logic        oBUSY
);
  localparam int TW = 30 - P_INDEX_W;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [P_INDEX_W-1:0] clr_idx, clr_idx_n, j_idx, s_idx, w_idx;
  logic [TW-1:0] j_tag, s_tag, w_tag, r_tag;
  logic [29:0] w_target, r_target;
  logic [1:0] j_cnt, w_cnt, r_cnt;
  logic tbl_valid [P_ENTRY_N];
  logic [TW-1:0] tbl_tag [P_ENTRY_N];
  logic [29:0] tbl_target [P_ENTRY_N];
  logic [1:0] tbl_cnt [P_ENTRY_N];
  logic clear_req, j_hit, upd, we, w_valid, r_valid, s_hit, unused_bits;
  assign unused_bits = ^{iJUMP_ADDR[1:0], iSEARCH_INST_ADDR[1:0], iJUMP_INST_ADDR[1:0]};
  assign clear_req = iRESET_SYNC || iFLUSH;
  assign oBUSY = state == CLEAR;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= clr_idx_n;
    end
  always_comb begin
    state_n = state;
    clr_idx_n = clr_idx;
    if (clear_req) begin
      state_n = CLEAR;
      clr_idx_n = '0;
    end else if (state == CLEAR) begin
      clr_idx_n = clr_idx + 1'b1;
      state_n = (clr_idx == P_INDEX_W'(P_ENTRY_N - 1)) ? IDLE : CLEAR;
    end
  end
  assign j_idx = iJUMP_INST_ADDR[P_INDEX_W+1:2];
  assign j_tag = iJUMP_INST_ADDR[31:P_INDEX_W+2];
  assign j_cnt = tbl_cnt[j_idx];
  assign j_hit = tbl_valid[j_idx] && tbl_tag[j_idx] == j_tag;
  // A not-taken miss leaves the table untouched.
  assign upd = state == IDLE && iJUMP_STB && !clear_req && (j_hit || iJUMP_HIT);
  always_comb begin
    we = state == CLEAR || upd;
    w_idx = state == CLEAR ? clr_idx : j_idx;
    w_valid = state != CLEAR;
    w_tag = state == CLEAR ? '0 : j_tag;
    w_target = state == CLEAR ? '0 : iJUMP_HIT ? iJUMP_ADDR[31:2] : tbl_target[j_idx];
    w_cnt = state == CLEAR ? 2'b01 : !j_hit ? 2'b10 :
            iJUMP_HIT ? (j_cnt == 2'b11 ? j_cnt : j_cnt + 2'd1) :
                        (j_cnt == 2'b00 ? j_cnt : j_cnt - 2'd1);
  end
  always_ff @(posedge iCLOCK)
    if (we) begin
      tbl_valid[w_idx] <= w_valid;
      tbl_tag[w_idx] <= w_tag;
      tbl_target[w_idx] <= w_target;
      tbl_cnt[w_idx] <= w_cnt;
    end
  assign s_idx = iSEARCH_INST_ADDR[P_INDEX_W+1:2];
  assign s_tag = iSEARCH_INST_ADDR[31:P_INDEX_W+2];
`ifdef BRANCH_PREDICTOR_BYPASS_EN
  logic byp;
  assign byp = upd && w_idx == s_idx;
  assign r_valid = byp ? w_valid : tbl_valid[s_idx];
  assign r_tag = byp ? w_tag : tbl_tag[s_idx];
  assign r_target = byp ? w_target : tbl_target[s_idx];
  assign r_cnt = byp ? w_cnt : tbl_cnt[s_idx];
`else
  assign r_valid = tbl_valid[s_idx];
  assign r_tag = tbl_tag[s_idx];
  assign r_target = tbl_target[s_idx];
  assign r_cnt = tbl_cnt[s_idx];
`endif
  assign s_hit = r_valid && r_tag == s_tag;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      oSEARCH_VALID <= 1'b0;
      oSEARCH_HIT <= 1'b0;
      oSEARCH_PREDICT_BRANCH <= 1'b0;
      oSEARCH_ADDR <= '0;
    end else if (iRESET_SYNC) begin
      oSEARCH_VALID <= 1'b0;
      oSEARCH_HIT <= 1'b0;
      oSEARCH_PREDICT_BRANCH <= 1'b0;
      oSEARCH_ADDR <= '0;
    end else if (!iSEARCH_LOCK || iFLUSH) begin
      oSEARCH_VALID <= iSEARCH_STB && state == IDLE && !iFLUSH;
      oSEARCH_HIT <= s_hit;
      oSEARCH_PREDICT_BRANCH <= s_hit && r_cnt[1];
      oSEARCH_ADDR <= s_hit ? {r_target, 2'b00} : '0;
    end
endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// tb_branch_predictor_bimodal: directed plan plus random traffic against a table-level reference model.
module tb_branch_predictor_bimodal;
  localparam int N = 16;
  logic clk = 0, rst_n = 0, rst_sync = 0, flush = 0;
  logic s_stb = 0, s_lock = 0, j_stb = 0, j_hit = 0;
  logic [31:0] s_addr = 0, j_addr = 0, j_inst = 0;
  logic o_valid, o_hit, o_pred, o_busy;
  logic [31:0] o_addr;
  int tests = 0, fails = 0;
  bit m_v [N];
  int unsigned m_tag [N];
  logic [31:0] m_tgt [N];
  int m_cnt [N];
  int m_left = N;
  bit e_valid = 0, e_hit = 0, e_pred = 0, e_known = 1;
  logic [31:0] e_addr = 0;

  always #5 clk = ~clk;

  branch_predictor_bimodal dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync), .iFLUSH(flush),
    .iSEARCH_STB(s_stb), .iSEARCH_INST_ADDR(s_addr), .iSEARCH_LOCK(s_lock),
    .oSEARCH_VALID(o_valid), .oSEARCH_HIT(o_hit), .oSEARCH_PREDICT_BRANCH(o_pred),
    .oSEARCH_ADDR(o_addr), .iJUMP_STB(j_stb), .iJUMP_HIT(j_hit), .iJUMP_ADDR(j_addr),
    .iJUMP_INST_ADDR(j_inst), .oBUSY(o_busy)
  );

  function automatic int idx_of(logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return a / (4 * N);
  endfunction

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model, advance the model, then compare.
  task automatic tick();
    bit busy, do_upd, jh, v, h;
    int ji, si, c, nc;
    int unsigned t;
    logic [31:0] g, ng;
    busy = m_left > 0;
    ji = idx_of(j_inst);
    si = idx_of(s_addr);
    jh = m_v[ji] && m_tag[ji] == tag_of(j_inst);
    do_upd = !busy && !flush && !rst_sync && j_stb && (jh || j_hit);
    nc = !jh ? 2 : j_hit ? (m_cnt[ji] < 3 ? m_cnt[ji] + 1 : 3) : (m_cnt[ji] > 0 ? m_cnt[ji] - 1 : 0);
    ng = j_hit ? (j_addr & 32'hFFFF_FFFC) : m_tgt[ji];
    v = m_v[si]; t = m_tag[si]; g = m_tgt[si]; c = m_cnt[si];
`ifdef BRANCH_PREDICTOR_BYPASS_EN
    if (do_upd && si == ji) begin
      v = 1; t = tag_of(j_inst); g = ng; c = nc;
    end
`endif
    h = v && t == tag_of(s_addr);
    if (rst_sync) begin
      e_valid = 0; e_hit = 0; e_pred = 0; e_addr = 0; e_known = 1;
    end else if (!s_lock || flush) begin
      e_valid = s_stb && !busy && !flush;
      e_hit = h; e_pred = h && c >= 2; e_addr = h ? g : 0;
      e_known = !busy;
    end
    if (do_upd) begin
      m_v[ji] = 1; m_tag[ji] = tag_of(j_inst); m_tgt[ji] = ng; m_cnt[ji] = nc;
    end
    if (rst_sync || flush) begin
      m_left = N;
      foreach (m_v[i]) begin
        m_v[i] = 0; m_cnt[i] = 1;
      end
    end else if (busy) m_left--;
    @(posedge clk);
    #1;
    check("busy", o_busy, m_left > 0);
    check("valid", o_valid, e_valid);
    if (e_known) begin
      check("hit", o_hit, e_hit);
      check("pred", o_pred, e_pred);
      check("addr", o_addr, e_addr);
    end
  endtask

  task automatic jump(logic [31:0] inst, logic [31:0] tgt, logic taken);
    j_stb = 1; j_inst = inst; j_addr = tgt; j_hit = taken; s_stb = 0;
    tick();
    j_stb = 0;
  endtask

  task automatic search(logic [31:0] a);
    s_stb = 1; s_addr = a;
    tick();
    s_stb = 0;
  endtask

  initial begin
    foreach (m_v[i]) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    #3;
    check("rst_busy", o_busy, 1);
    check("rst_valid", o_valid, 0);
    check("rst_addr", o_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    s_stb = 1; s_addr = 32'h100;
    repeat (N) tick();
    tick();
    check("post_clear_valid", o_valid, 1);
    check("post_clear_hit", o_hit, 0);
    jump(32'h100, 32'h2000, 1);
    search(32'h100);
    check("train_hit", o_hit, 1);
    check("train_addr", o_addr, 32'h2000);
    jump(32'h100, 32'h0, 0);
    jump(32'h100, 32'h0, 0);
    search(32'h100);
    check("weak_pred", o_pred, 0);
    for (int k = 0; k < 3; k++) begin
      jump(32'h100, 32'h2000, 1);
      search(32'h100);
    end
    check("sat_pred", o_pred, 1);
    search(32'h140);
    check("alias_hit", o_hit, 0);
    jump(32'h140, 32'h3000, 1);
    search(32'h100);
    check("evicted_hit", o_hit, 0);
    s_stb = 1; s_addr = 32'h140;
    tick();
    s_lock = 1;
    for (int k = 0; k < 3; k++) begin
      s_addr = 32'h200 + 32'(k * 4);
      tick();
      check("lock_addr", o_addr, 32'h3000);
    end
    flush = 1;
    tick();
    flush = 0; s_lock = 0;
    check("flush_valid", o_valid, 0);
    repeat (N) tick();
    s_stb = 1; s_addr = 32'h100; j_stb = 1; j_hit = 1; j_inst = 32'h100; j_addr = 32'h2000;
    tick();
    j_stb = 0;
`ifdef BRANCH_PREDICTOR_BYPASS_EN
    check("same_cycle_hit", o_hit, 1);
    check("same_cycle_addr", o_addr, 32'h2000);
`else
    check("same_cycle_hit", o_hit, 0);
    check("same_cycle_addr", o_addr, 0);
`endif
    for (int k = 0; k < 600; k++) begin
      s_stb = $urandom_range(0, 9) < 8;
      s_addr = 32'($urandom_range(0, 3)) * 64 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      s_lock = $urandom_range(0, 9) < 2;
      j_stb = $urandom_range(0, 1);
      j_hit = $urandom_range(0, 2) != 0;
      j_inst = 32'($urandom_range(0, 3)) * 64 + 32'($urandom_range(0, 15)) * 4;
      j_addr = $urandom;
      flush = $urandom_range(0, 99) < 2;
      rst_sync = $urandom_range(0, 199) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
